// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: bundle between the VGA raster engine and its pixel source / sink.
//
// Signals (CW = counter width):
//   ce           advance enable supplied to the engine
//   pixel_in     RGB332 pixel data returned by the framebuffer
//   hc, vc       raw horizontal / vertical counters
//   pix_x, pix_y scaled framebuffer address, 0 outside the active area
//   pix_req      current hc/vc lies in the active area
//   hsync, vsync sync pins, aligned with the colour pins
//   red/green/blue 4-bit colour pins
//   frame_start, vblank_start one-clock strobes for buffer swapping
//
// Modports:
//   master  the raster engine (drives addresses, pins and strobes)
//   slave   the surrounding system (drives ce and pixel_in)
interface vga_timing_gen_if #(
  parameter int unsigned CW = 10
) ();

  logic          ce;
  logic [7:0]    pixel_in;
  logic [CW-1:0] hc;
  logic [CW-1:0] vc;
  logic [CW-1:0] pix_x;
  logic [CW-1:0] pix_y;
  logic          pix_req;
  logic          hsync;
  logic          vsync;
  logic [3:0]    red;
  logic [3:0]    green;
  logic [3:0]    blue;
  logic          frame_start;
  logic          vblank_start;

  modport master (
    input  ce,
    input  pixel_in,
    output hc,
    output vc,
    output pix_x,
    output pix_y,
    output pix_req,
    output hsync,
    output vsync,
    output red,
    output green,
    output blue,
    output frame_start,
    output vblank_start
  );

  modport slave (
    output ce,
    output pixel_in,
    input  hc,
    input  vc,
    input  pix_x,
    input  pix_y,
    input  pix_req,
    input  hsync,
    input  vsync,
    input  red,
    input  green,
    input  blue,
    input  frame_start,
    input  vblank_start
  );

endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster engine.
//
// Generates the horizontal/vertical counters, a scaled framebuffer address, and the
// sync and colour pins. Pixel data returns LAT ce-cycles after its address, so the sync
// and active terms travel through a LAT-deep shift register and are then registered
// together with the colour, keeping every pin aligned with pixel_in.
//
// Ports:
//   clk_25MHz  pixel clock
//   rst_n      synchronous active-low reset (wins over ce)
//   vga        master side of vga_timing_gen_if (ce, pixel_in in; counters, address,
//              pins and frame/vblank strobes out)
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter bit          HS_POL      = 1'b0,
  parameter bit          VS_POL      = 1'b0,
  parameter int unsigned SCALE_SHIFT = 0,
  parameter int unsigned LAT         = 1,
  parameter int unsigned CW          = 10
) (
  input  logic             clk_25MHz,
  input  logic             rst_n,
  vga_timing_gen_if.master vga
);

  localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HSyncStart = H_ACTIVE + H_FP;
  localparam int unsigned HSyncEnd   = HSyncStart + H_SYNC;
  localparam int unsigned VSyncStart = V_ACTIVE + V_FP;
  localparam int unsigned VSyncEnd   = VSyncStart + V_SYNC;

  // Elaboration-time guards on the parameter set.
  if (SCALE_SHIFT > 3) begin : g_bad_scale
    $error("vga_timing_gen: SCALE_SHIFT must be in 0..3");
  end
  if (LAT < 1 || LAT > 4) begin : g_bad_lat
    $error("vga_timing_gen: LAT must be in 1..4");
  end
  if (CW < 1 || CW > 31) begin : g_bad_cw_range
    $error("vga_timing_gen: CW must be in 1..31");
  end else if ((longint'(H_TOTAL) > (longint'(1) << CW)) ||
               (longint'(V_TOTAL) > (longint'(1) << CW))) begin : g_bad_cw
    $error("vga_timing_gen: CW too small for H_TOTAL-1 / V_TOTAL-1");
  end
  if (H_ACTIVE == 0 || V_ACTIVE == 0) begin : g_bad_active
    $error("vga_timing_gen: active area must be non-empty");
  end

  localparam logic [CW-1:0] HLast       = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] VLast       = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] VLastActive = CW'(V_ACTIVE - 1);

  // One pipeline tap: active flag plus raw (active-high) sync terms.
  typedef struct packed {
    logic act;
    logic vs;
    logic hs;
  } tap_t;

  logic [CW-1:0] hc_q, hc_d;
  logic [CW-1:0] vc_q, vc_d;
  tap_t [LAT-1:0] pipe_q, pipe_d;
  tap_t          last_tap;

  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic [3:0]    red_q, red_d;
  logic [3:0]    green_q, green_d;
  logic [3:0]    blue_q, blue_d;
  logic          frame_q, frame_d;
  logic          vblank_q, vblank_d;

  logic          h_end;
  logic          v_end;
  logic          v_last_active;
  logic          pix_req;
  logic          h_sync_raw;
  logic          v_sync_raw;
  logic [31:0]   hc_w;
  logic [31:0]   vc_w;
  logic [2:0]    pix_r;
  logic [2:0]    pix_g;
  logic [1:0]    pix_b;

  // Compare in 32 bits so sync windows ending exactly at the total cannot overflow CW.
  assign hc_w = 32'(hc_q);
  assign vc_w = 32'(vc_q);

  assign h_end         = (hc_q == HLast);
  assign v_end         = (vc_q == VLast);
  assign v_last_active = (vc_q == VLastActive);

  assign pix_req    = (hc_w < H_ACTIVE) && (vc_w < V_ACTIVE);
  assign h_sync_raw = (hc_w >= HSyncStart) && (hc_w < HSyncEnd);
  assign v_sync_raw = (vc_w >= VSyncStart) && (vc_w < VSyncEnd);

  assign last_tap = pipe_q[LAT-1];

  assign pix_r = vga.pixel_in[7:5];
  assign pix_g = vga.pixel_in[4:2];
  assign pix_b = vga.pixel_in[1:0];

  // Next-state: everything holds unless ce; strobes default low so they stay one clock wide.
  always_comb begin
    hc_d     = hc_q;
    vc_d     = vc_q;
    pipe_d   = pipe_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    red_d    = red_q;
    green_d  = green_q;
    blue_d   = blue_q;
    frame_d  = 1'b0;
    vblank_d = 1'b0;

    if (vga.ce) begin
      hc_d = h_end ? '0 : hc_q + CW'(1);
      if (h_end) begin
        vc_d = v_end ? '0 : vc_q + CW'(1);
      end

      pipe_d[0] = '{act: pix_req, vs: v_sync_raw, hs: h_sync_raw};
      for (int unsigned i = 1; i < LAT; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end

      hsync_d = last_tap.hs ? HS_POL : ~HS_POL;
      vsync_d = last_tap.vs ? VS_POL : ~VS_POL;

      // Replicate MSBs so full-scale 3/2-bit values map to full-scale 4-bit values.
      if (last_tap.act) begin
        red_d   = {pix_r, pix_r[2]};
        green_d = {pix_g, pix_g[2]};
        blue_d  = {pix_b, pix_b};
      end else begin
        red_d   = 4'h0;
        green_d = 4'h0;
        blue_d  = 4'h0;
      end

      frame_d  = h_end && v_end;
      vblank_d = h_end && v_last_active;
    end
  end

  always_ff @(posedge clk_25MHz) begin
    if (!rst_n) begin
      hc_q     <= '0;
      vc_q     <= '0;
      pipe_q   <= '0;
      hsync_q  <= ~HS_POL;
      vsync_q  <= ~VS_POL;
      red_q    <= 4'h0;
      green_q  <= 4'h0;
      blue_q   <= 4'h0;
      frame_q  <= 1'b0;
      vblank_q <= 1'b0;
    end else begin
      hc_q     <= hc_d;
      vc_q     <= vc_d;
      pipe_q   <= pipe_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      red_q    <= red_d;
      green_q  <= green_d;
      blue_q   <= blue_d;
      frame_q  <= frame_d;
      vblank_q <= vblank_d;
    end
  end

  assign vga.hc           = hc_q;
  assign vga.vc           = vc_q;
  assign vga.pix_req      = pix_req;
  assign vga.pix_x        = pix_req ? (hc_q >> SCALE_SHIFT) : '0;
  assign vga.pix_y        = pix_req ? (vc_q >> SCALE_SHIFT) : '0;
  assign vga.hsync        = hsync_q;
  assign vga.vsync        = vsync_q;
  assign vga.red          = red_q;
  assign vga.green        = green_q;
  assign vga.blue         = blue_q;
  assign vga.frame_start  = frame_q;
  assign vga.vblank_start = vblank_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: self-checking bench for vga_timing_gen.
//
// Two instances share clock, reset, ce and pixel_in over a reduced raster (25 x 15) so
// several frames fit in a short run: instance A is LAT=1, no scaling, active-low syncs;
// instance B is LAT=3, SCALE_SHIFT=1, active-high syncs. The reference model counts ce
// advances since reset and derives every expected pin from that count arithmetically.
module tb_vga_timing_gen;

  localparam int HA = 16;
  localparam int HF = 2;
  localparam int HS = 4;
  localparam int HB = 3;
  localparam int VA = 8;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int CW = 5;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
  localparam int SH_B = 1;

  logic       clk_25MHz = 1'b0;
  logic       rst_n;
  logic       ce;
  logic [7:0] pixel_in;

  int checks = 0;
  int passed = 0;

  always #20 clk_25MHz = ~clk_25MHz;

  vga_timing_gen_if #(.CW(CW)) if_a ();
  vga_timing_gen_if #(.CW(CW)) if_b ();

  assign if_a.ce       = ce;
  assign if_a.pixel_in = pixel_in;
  assign if_b.ce       = ce;
  assign if_b.pixel_in = pixel_in;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .SCALE_SHIFT(0), .LAT(LAT_A), .CW(CW)
  ) u_dut_a (
    .clk_25MHz(clk_25MHz),
    .rst_n    (rst_n),
    .vga      (if_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .SCALE_SHIFT(SH_B), .LAT(LAT_B), .CW(CW)
  ) u_dut_b (
    .clk_25MHz(clk_25MHz),
    .rst_n    (rst_n),
    .vga      (if_b)
  );

  // Reference model: n = ce advances since reset; strobes from the pre-edge count.
  int         n;
  logic [7:0] last_pix;
  logic       fs_e;
  logic       vb_e;

  always @(posedge clk_25MHz) begin
    if (!rst_n) begin
      n    <= 0;
      fs_e <= 1'b0;
      vb_e <= 1'b0;
    end else begin
      fs_e <= ce && ((n % FT) == FT - 1);
      vb_e <= ce && ((n % FT) == VA * HT - 1);
      if (ce) begin
        n        <= n + 1;
        last_pix <= pixel_in;
      end
    end
  end

  function automatic int hpos(int k);
    return k % HT;
  endfunction

  function automatic int vpos(int k);
    return (k / HT) % VT;
  endfunction

  function automatic bit act(int k);
    return (hpos(k) < HA) && (vpos(k) < VA);
  endfunction

  // Pins after k advances show position k-lat-1; before that the pipe is still clear.
  function automatic logic e_hs(int k, int lat, logic pol);
    int m = k - lat - 1;
    if (m < 0) return ~pol;
    return (hpos(m) >= HA + HF && hpos(m) < HA + HF + HS) ? pol : ~pol;
  endfunction

  function automatic logic e_vs(int k, int lat, logic pol);
    int m = k - lat - 1;
    if (m < 0) return ~pol;
    return (vpos(m) >= VA + VF && vpos(m) < VA + VF + VS) ? pol : ~pol;
  endfunction

  function automatic logic [11:0] e_col(int k, int lat, logic [7:0] p);
    int m = k - lat - 1;
    if (m < 0 || !act(m)) return 12'h000;
    return {p[7:5], p[7], p[4:2], p[4], p[1:0], p[1:0]};
  endfunction

  function automatic logic [CW-1:0] e_px(int k, int sh);
    return act(k) ? CW'(hpos(k) >> sh) : '0;
  endfunction

  function automatic logic [CW-1:0] e_py(int k, int sh);
    return act(k) ? CW'(vpos(k) >> sh) : '0;
  endfunction

  task automatic tick();
    @(posedge clk_25MHz);
    @(negedge clk_25MHz);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) begin
      ce       = 1'($urandom % 2);
      pixel_in = 8'($urandom);
      tick();
    end
    checks++; if (if_a.hc !== '0) $display("FAIL rst_hc got %0d want 0", if_a.hc);
    else passed++;
    checks++; if (if_a.vc !== '0) $display("FAIL rst_vc got %0d want 0", if_a.vc);
    else passed++;
    checks++; if (if_a.hsync !== 1'b1) $display("FAIL rst_hsync_a got %b want 1", if_a.hsync);
    else passed++;
    checks++; if (if_a.vsync !== 1'b1) $display("FAIL rst_vsync_a got %b want 1", if_a.vsync);
    else passed++;
    checks++; if (if_b.hsync !== 1'b0) $display("FAIL rst_hsync_b got %b want 0", if_b.hsync);
    else passed++;
    checks++; if (if_b.vsync !== 1'b0) $display("FAIL rst_vsync_b got %b want 0", if_b.vsync);
    else passed++;
    checks++;
    if ({if_a.red, if_a.green, if_a.blue} !== 12'h000)
      $display("FAIL rst_colour got %h want 000", {if_a.red, if_a.green, if_a.blue});
    else passed++;
    checks++;
    if (if_a.frame_start !== 1'b0 || if_a.vblank_start !== 1'b0)
      $display("FAIL rst_strobes got %b%b want 00", if_a.frame_start, if_a.vblank_start);
    else passed++;
    checks++;
    if (if_a.pix_req !== 1'b1 || if_a.pix_x !== '0)
      $display("FAIL rst_addr got req=%b x=%0d want req=1 x=0", if_a.pix_req, if_a.pix_x);
    else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_counters();
    int fs_cnt = 0;
    ce = 1'b1;
    repeat (2 * FT + 10) begin
      pixel_in = 8'($urandom);
      tick();
      checks++;
      if (if_a.hc !== CW'(hpos(n))) $display("FAIL hc n=%0d got %0d want %0d", n, if_a.hc, hpos(n));
      else passed++;
      checks++;
      if (if_a.vc !== CW'(vpos(n))) $display("FAIL vc n=%0d got %0d want %0d", n, if_a.vc, vpos(n));
      else passed++;
      checks++;
      if (if_a.pix_req !== act(n)) $display("FAIL pix_req n=%0d got %b want %b", n, if_a.pix_req, act(n));
      else passed++;
      checks++;
      if (if_a.pix_x !== e_px(n, 0) || if_a.pix_y !== e_py(n, 0))
        $display("FAIL addr_a n=%0d got %0d,%0d want %0d,%0d", n, if_a.pix_x, if_a.pix_y,
                 e_px(n, 0), e_py(n, 0));
      else passed++;
      checks++;
      if (if_b.pix_x !== e_px(n, SH_B) || if_b.pix_y !== e_py(n, SH_B) || if_b.pix_req !== act(n))
        $display("FAIL addr_b n=%0d got %0d,%0d,%b want %0d,%0d,%b", n, if_b.pix_x, if_b.pix_y,
                 if_b.pix_req, e_px(n, SH_B), e_py(n, SH_B), act(n));
      else passed++;
      if (if_a.frame_start === 1'b1) fs_cnt++;
    end
    checks++;
    if (fs_cnt != 2) $display("FAIL frame_count got %0d want 2", fs_cnt);
    else passed++;
  endtask

  task automatic test_sync_colour();
    ce = 1'b1;
    for (int c = 0; c < 2 * FT; c++) begin
      pixel_in = (c < FT) ? 8'b101_010_11 : 8'($urandom);
      tick();
      checks++;
      if (if_a.hsync !== e_hs(n, LAT_A, 1'b0) || if_a.vsync !== e_vs(n, LAT_A, 1'b0))
        $display("FAIL sync_a n=%0d got %b%b want %b%b", n, if_a.hsync, if_a.vsync,
                 e_hs(n, LAT_A, 1'b0), e_vs(n, LAT_A, 1'b0));
      else passed++;
      checks++;
      if (if_b.hsync !== e_hs(n, LAT_B, 1'b1) || if_b.vsync !== e_vs(n, LAT_B, 1'b1))
        $display("FAIL sync_b n=%0d got %b%b want %b%b", n, if_b.hsync, if_b.vsync,
                 e_hs(n, LAT_B, 1'b1), e_vs(n, LAT_B, 1'b1));
      else passed++;
      checks++;
      if ({if_a.red, if_a.green, if_a.blue} !== e_col(n, LAT_A, last_pix))
        $display("FAIL colour_a n=%0d got %h want %h", n, {if_a.red, if_a.green, if_a.blue},
                 e_col(n, LAT_A, last_pix));
      else passed++;
      checks++;
      if ({if_b.red, if_b.green, if_b.blue} !== e_col(n, LAT_B, last_pix))
        $display("FAIL colour_b n=%0d got %h want %h", n, {if_b.red, if_b.green, if_b.blue},
                 e_col(n, LAT_B, last_pix));
      else passed++;
      checks++;
      if (if_a.frame_start !== fs_e || if_a.vblank_start !== vb_e)
        $display("FAIL strobes n=%0d got %b%b want %b%b", n, if_a.frame_start, if_a.vblank_start,
                 fs_e, vb_e);
      else passed++;
    end
  endtask

  task automatic test_ce_toggle();
    int p0 = -1;
    int p1 = -1;
    for (int c = 0; c < 4 * FT + 4 + 500; c++) begin
      ce       = (c < 4 * FT + 4) ? ((c % 2) == 0) : 1'($urandom % 2);
      pixel_in = 8'($urandom);
      tick();
      if (if_a.frame_start === 1'b1 && c < 4 * FT + 4) begin
        if (p0 < 0) p0 = c;
        else if (p1 < 0) p1 = c;
      end
      checks++;
      if (if_a.hc !== CW'(hpos(n)) || if_a.vc !== CW'(vpos(n)))
        $display("FAIL ce_count n=%0d got %0d,%0d want %0d,%0d", n, if_a.hc, if_a.vc,
                 hpos(n), vpos(n));
      else passed++;
      checks++;
      if (if_a.hsync !== e_hs(n, LAT_A, 1'b0) || if_b.hsync !== e_hs(n, LAT_B, 1'b1) ||
          if_a.vsync !== e_vs(n, LAT_A, 1'b0))
        $display("FAIL ce_sync n=%0d got %b%b%b want %b%b%b", n, if_a.hsync, if_b.hsync,
                 if_a.vsync, e_hs(n, LAT_A, 1'b0), e_hs(n, LAT_B, 1'b1), e_vs(n, LAT_A, 1'b0));
      else passed++;
      checks++;
      if ({if_a.red, if_a.green, if_a.blue} !== e_col(n, LAT_A, last_pix) ||
          {if_b.red, if_b.green, if_b.blue} !== e_col(n, LAT_B, last_pix))
        $display("FAIL ce_colour n=%0d got %h,%h want %h,%h", n, {if_a.red, if_a.green, if_a.blue},
                 {if_b.red, if_b.green, if_b.blue}, e_col(n, LAT_A, last_pix),
                 e_col(n, LAT_B, last_pix));
      else passed++;
      checks++;
      if (if_a.frame_start !== fs_e || if_a.vblank_start !== vb_e)
        $display("FAIL ce_strobes n=%0d got %b%b want %b%b", n, if_a.frame_start,
                 if_a.vblank_start, fs_e, vb_e);
      else passed++;
    end
    checks++;
    if (p0 < 0 || p1 < 0 || (p1 - p0) != 2 * FT)
      $display("FAIL ce_frame_period got %0d want %0d", p1 - p0, 2 * FT);
    else passed++;
  endtask

  task automatic test_midframe_reset();
    bit found = 1'b0;
    int cyc = 0;
    int fs_seen = 0;
    ce = 1'b1;
    for (int c = 0; c < 2 * FT; c++) begin
      pixel_in = 8'($urandom);
      tick();
      if (if_a.hc == CW'(10) && if_a.vc == CW'(5)) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) $display("FAIL mid_reach got 0 want 1");
    else passed++;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (if_a.hc !== '0 || if_a.vc !== '0)
      $display("FAIL mid_counters got %0d,%0d want 0,0", if_a.hc, if_a.vc);
    else passed++;
    checks++;
    if (if_a.hsync !== 1'b1 || if_a.vsync !== 1'b1)
      $display("FAIL mid_sync got %b%b want 11", if_a.hsync, if_a.vsync);
    else passed++;
    checks++;
    if ({if_a.red, if_a.green, if_a.blue, if_b.red, if_b.green, if_b.blue} !== 24'h0)
      $display("FAIL mid_colour got %h,%h want 0", {if_a.red, if_a.green, if_a.blue},
               {if_b.red, if_b.green, if_b.blue});
    else passed++;
    checks++;
    if (if_a.frame_start !== 1'b0) $display("FAIL mid_no_frame got %b want 0", if_a.frame_start);
    else passed++;
    while (cyc < 2 * FT) begin
      tick();
      cyc++;
      if (if_a.frame_start === 1'b1) fs_seen++;
      if (if_a.vblank_start === 1'b1) break;
    end
    checks++;
    if (cyc != VA * HT) $display("FAIL mid_vblank_delay got %0d want %0d", cyc, VA * HT);
    else passed++;
    checks++;
    if (if_a.vc !== CW'(VA) || if_a.hc !== '0)
      $display("FAIL mid_vblank_pos got %0d,%0d want 0,%0d", if_a.hc, if_a.vc, VA);
    else passed++;
    checks++;
    if (fs_seen != 0) $display("FAIL mid_spurious_frame got %0d want 0", fs_seen);
    else passed++;
  endtask

  initial begin
    rst_n    = 1'b0;
    ce       = 1'b0;
    pixel_in = 8'h00;
    test_reset();
    test_counters();
    test_sync_colour();
    test_ce_toggle();
    test_midframe_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #50_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
